// File: rtl/fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_redirect_ctrl
//  Purpose  : Front-end fetch sequencer. Owns the fetch PC, picks one redirect
//             per cycle by fixed priority (ROB > BR > D1 > RAS), produces the
//             even/odd I$ line addresses, sequences the F1/F2 flush bubble and
//             restores the BHR on ROB/BR redirects.
//  Ports    : clk, rst (async, active-low)
//             stall_in / ic_stall         - hold the PC while in RUN
//             exception_ROB, mispredict_BR, resteer_taken_D1, ras_valid
//                                         - redirect requests + targets/BHRs
//             fetch_valid, fetch_pc       - registered fetch request
//             cache_addr_even/odd         - combinational line addresses
//             flush_f1/flush_f2           - one-cycle kill pulse per redirect
//             redirect_src                - 00 none, 01 RAS, 10 D1, 11 BR/ROB
//             bhr_restore_valid/bhr_restore
//  Option   : define REDIRECT_STATS_EN to add saturating 16-bit per-source
//             redirect counters (stat_rob, stat_br, stat_d1, stat_ras).
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_redirect_ctrl #(
    parameter int              XLEN         = 32,
    parameter int              CL_SIZE      = 128,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_in,
    input  logic            ic_stall,
    input  logic            exception_ROB,
    input  logic [XLEN-1:0] resteer_target_ROB,
    input  logic [9:0]      bhr_update_ROB,
    input  logic            mispredict_BR,
    input  logic [XLEN-1:0] resteer_target_BR,
    input  logic [9:0]      bhr_update_BR,
    input  logic            resteer_taken_D1,
    input  logic [XLEN-1:0] resteer_target_D1,
    input  logic            ras_valid,
    input  logic [XLEN-1:0] ras_target,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_pc,
    output logic [XLEN-1:0] cache_addr_even,
    output logic [XLEN-1:0] cache_addr_odd,
    output logic            flush_f1,
    output logic            flush_f2,
    output logic [1:0]      redirect_src,
`ifdef REDIRECT_STATS_EN
    output logic [15:0]     stat_rob,
    output logic [15:0]     stat_br,
    output logic [15:0]     stat_d1,
    output logic [15:0]     stat_ras,
`endif
    output logic            bhr_restore_valid,
    output logic [9:0]      bhr_restore
);

    localparam int              c_line_bytes = CL_SIZE / 8;
    localparam int              c_offs       = $clog2(c_line_bytes);
    localparam logic [XLEN-1:0] c_line_step  = XLEN'(c_line_bytes);
    localparam logic [XLEN-1:0] c_off_mask   = XLEN'(c_line_bytes - 1);
    localparam logic [2:0]      c_flush_load = 3'(FLUSH_CYCLES);

    localparam logic [1:0] c_st_boot  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_flush = 2'd2;

    localparam logic [1:0] c_src_none   = 2'b00;
    localparam logic [1:0] c_src_ras    = 2'b01;
    localparam logic [1:0] c_src_d1     = 2'b10;
    localparam logic [1:0] c_src_br_rob = 2'b11;

    logic [1:0]      r_state;
    logic [2:0]      r_cnt;
    logic            r_fetch_valid;
    logic [XLEN-1:0] r_fetch_pc;
    logic            r_flush;
    logic [1:0]      r_src;
    logic            r_bhr_valid;
    logic [9:0]      r_bhr;

    logic            w_accept;
    logic            w_redirect;
    logic [XLEN-1:0] w_target;
    logic [1:0]      w_src;
    logic            w_bhr_valid;
    logic [9:0]      w_bhr;
    logic [XLEN-1:0] w_line;
    logic [XLEN-1:0] w_line_next;

    // Requests are ignored only during the single BOOT cycle; stalls never
    // block a redirect.
    assign w_accept = (r_state != c_st_boot);

    always_comb begin
        w_redirect  = 1'b0;
        w_target    = r_fetch_pc;
        w_src       = c_src_none;
        w_bhr_valid = 1'b0;
        w_bhr       = bhr_update_ROB;
        if (w_accept) begin
            if (exception_ROB) begin
                w_redirect  = 1'b1;
                w_target    = resteer_target_ROB;
                w_src       = c_src_br_rob;
                w_bhr_valid = 1'b1;
                w_bhr       = bhr_update_ROB;
            end else if (mispredict_BR) begin
                w_redirect  = 1'b1;
                w_target    = resteer_target_BR;
                w_src       = c_src_br_rob;
                w_bhr_valid = 1'b1;
                w_bhr       = bhr_update_BR;
            end else if (resteer_taken_D1) begin
                w_redirect  = 1'b1;
                w_target    = resteer_target_D1;
                w_src       = c_src_d1;
            end else if (ras_valid) begin
                w_redirect  = 1'b1;
                w_target    = ras_target;
                w_src       = c_src_ras;
            end
        end
    end

    // The line holding fetch_pc goes to the bank matching its index parity;
    // the following line (modulo 2^XLEN) fills the other bank.
    assign w_line          = r_fetch_pc & ~c_off_mask;
    assign w_line_next     = w_line + c_line_step;
    assign cache_addr_even = w_line[c_offs] ? w_line_next : w_line;
    assign cache_addr_odd  = w_line[c_offs] ? w_line : w_line_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_st_boot;
            r_cnt         <= 3'd0;
            r_fetch_valid <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_flush       <= 1'b0;
            r_src         <= c_src_none;
            r_bhr_valid   <= 1'b0;
            r_bhr         <= 10'd0;
        end else begin
            r_flush     <= w_redirect;
            r_src       <= w_src;
            r_bhr_valid <= w_bhr_valid;
            if (w_bhr_valid) begin
                r_bhr <= w_bhr;
            end
            if (w_redirect) begin
                // Target taken unaligned; a redirect inside FLUSH restarts
                // the full bubble.
                r_fetch_pc    <= w_target;
                r_state       <= c_st_flush;
                r_cnt         <= c_flush_load;
                r_fetch_valid <= 1'b0;
            end else begin
                case (r_state)
                    c_st_boot: begin
                        r_state       <= c_st_run;
                        r_fetch_valid <= 1'b1;
                    end
                    c_st_run: begin
                        if (!stall_in && !ic_stall) begin
                            r_fetch_pc <= w_line_next;
                        end
                    end
                    c_st_flush: begin
                        // Bubble drains even under stall; leaving on the edge
                        // where the count reaches zero gives FLUSH_CYCLES
                        // invalid cycles.
                        if (r_cnt <= 3'd1) begin
                            r_cnt         <= 3'd0;
                            r_state       <= c_st_run;
                            r_fetch_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 3'd1;
                        end
                    end
                    default: begin
                        r_state       <= c_st_boot;
                        r_fetch_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign fetch_valid       = r_fetch_valid;
    assign fetch_pc          = r_fetch_pc;
    assign flush_f1          = r_flush;
    assign flush_f2          = r_flush;
    assign redirect_src      = r_src;
    assign bhr_restore_valid = r_bhr_valid;
    assign bhr_restore       = r_bhr;

`ifdef REDIRECT_STATS_EN
    logic        w_win_rob;
    logic        w_win_br;
    logic        w_win_d1;
    logic        w_win_ras;
    logic [15:0] r_stat_rob;
    logic [15:0] r_stat_br;
    logic [15:0] r_stat_d1;
    logic [15:0] r_stat_ras;

    assign w_win_rob = w_accept & exception_ROB;
    assign w_win_br  = w_accept & ~exception_ROB & mispredict_BR;
    assign w_win_d1  = w_accept & ~exception_ROB & ~mispredict_BR & resteer_taken_D1;
    assign w_win_ras = w_accept & ~exception_ROB & ~mispredict_BR & ~resteer_taken_D1
                       & ras_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_rob <= 16'd0;
            r_stat_br  <= 16'd0;
            r_stat_d1  <= 16'd0;
            r_stat_ras <= 16'd0;
        end else begin
            if (w_win_rob && (r_stat_rob != 16'hFFFF)) r_stat_rob <= r_stat_rob + 16'd1;
            if (w_win_br  && (r_stat_br  != 16'hFFFF)) r_stat_br  <= r_stat_br  + 16'd1;
            if (w_win_d1  && (r_stat_d1  != 16'hFFFF)) r_stat_d1  <= r_stat_d1  + 16'd1;
            if (w_win_ras && (r_stat_ras != 16'hFFFF)) r_stat_ras <= r_stat_ras + 16'd1;
        end
    end

    assign stat_rob = r_stat_rob;
    assign stat_br  = r_stat_br;
    assign stat_d1  = r_stat_d1;
    assign stat_ras = r_stat_ras;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_redirect_ctrl
//  Purpose  : Self-checking bench for fetch_redirect_ctrl: a vector table for
//             the directed scenarios, hand sequences for wrap-around and the
//             asynchronous reset pulse, and a randomized run against a
//             behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_redirect_ctrl;

    localparam int          c_xlen     = 32;
    localparam logic [31:0] c_reset_pc = 32'h0000_0100;
    localparam int          c_flush    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_in = 1'b0;
    logic        ic_stall = 1'b0;
    logic        exception_ROB = 1'b0;
    logic [31:0] resteer_target_ROB = '0;
    logic [9:0]  bhr_update_ROB = '0;
    logic        mispredict_BR = 1'b0;
    logic [31:0] resteer_target_BR = '0;
    logic [9:0]  bhr_update_BR = '0;
    logic        resteer_taken_D1 = 1'b0;
    logic [31:0] resteer_target_D1 = '0;
    logic        ras_valid = 1'b0;
    logic [31:0] ras_target = '0;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] cache_addr_even;
    logic [31:0] cache_addr_odd;
    logic        flush_f1;
    logic        flush_f2;
    logic [1:0]  redirect_src;
    logic        bhr_restore_valid;
    logic [9:0]  bhr_restore;
`ifdef REDIRECT_STATS_EN
    logic [15:0] stat_rob;
    logic [15:0] stat_br;
    logic [15:0] stat_d1;
    logic [15:0] stat_ras;
`endif

    fetch_redirect_ctrl #(
        .XLEN         (c_xlen),
        .CL_SIZE      (128),
        .RESET_PC     (c_reset_pc),
        .FLUSH_CYCLES (c_flush)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .stall_in           (stall_in),
        .ic_stall           (ic_stall),
        .exception_ROB      (exception_ROB),
        .resteer_target_ROB (resteer_target_ROB),
        .bhr_update_ROB     (bhr_update_ROB),
        .mispredict_BR      (mispredict_BR),
        .resteer_target_BR  (resteer_target_BR),
        .bhr_update_BR      (bhr_update_BR),
        .resteer_taken_D1   (resteer_taken_D1),
        .resteer_target_D1  (resteer_target_D1),
        .ras_valid          (ras_valid),
        .ras_target         (ras_target),
        .fetch_valid        (fetch_valid),
        .fetch_pc           (fetch_pc),
        .cache_addr_even    (cache_addr_even),
        .cache_addr_odd     (cache_addr_odd),
        .flush_f1           (flush_f1),
        .flush_f2           (flush_f2),
        .redirect_src       (redirect_src),
`ifdef REDIRECT_STATS_EN
        .stat_rob           (stat_rob),
        .stat_br            (stat_br),
        .stat_d1            (stat_d1),
        .stat_ras           (stat_ras),
`endif
        .bhr_restore_valid  (bhr_restore_valid),
        .bhr_restore        (bhr_restore)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // req bits: {ROB, BR, D1, RAS}
    task automatic drive_req(input logic [3:0] req);
        exception_ROB    = req[3];
        mispredict_BR    = req[2];
        resteer_taken_D1 = req[1];
        ras_valid        = req[0];
    endtask

    // ---------------- reference model ----------------
    bit          m_booting;
    int          m_bubbles;
    logic [31:0] m_pc;
    logic        e_flush;
    logic [1:0]  e_src;
    logic        e_bhrv;
    logic [9:0]  e_bhr;
    logic [15:0] m_stat[4];   // index 0 ROB, 1 BR, 2 D1, 3 RAS

    function automatic logic [31:0] line_of(input logic [31:0] pc);
        return pc - (pc % 32'd16);
    endfunction

    function automatic logic [31:0] exp_even(input logic [31:0] pc);
        logic [31:0] base;
        base = line_of(pc);
        if (((base / 32'd16) % 32'd2) == 32'd0) return base;
        return base + 32'd16;
    endfunction

    function automatic logic [31:0] exp_odd(input logic [31:0] pc);
        logic [31:0] base;
        base = line_of(pc);
        if (((base / 32'd16) % 32'd2) == 32'd1) return base;
        return base + 32'd16;
    endfunction

    task automatic model_reset();
        m_booting = 1'b1;
        m_bubbles = 0;
        m_pc      = c_reset_pc;
        e_flush   = 1'b0;
        e_src     = 2'b00;
        e_bhrv    = 1'b0;
        e_bhr     = 10'd0;
        for (int i = 0; i < 4; i++) m_stat[i] = 16'd0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_cycle();
        logic [3:0]  reqs;
        logic [31:0] tg[4];
        int          w;
        reqs  = {ras_valid, resteer_taken_D1, mispredict_BR, exception_ROB};
        tg[0] = resteer_target_ROB;
        tg[1] = resteer_target_BR;
        tg[2] = resteer_target_D1;
        tg[3] = ras_target;
        w       = -1;
        e_flush = 1'b0;
        e_src   = 2'b00;
        e_bhrv  = 1'b0;
        if (m_booting) begin
            m_booting = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) if (reqs[i] && w < 0) w = i;
            if (w >= 0) begin
                m_pc      = tg[w];
                m_bubbles = c_flush;
                e_flush   = 1'b1;
                e_src     = (w < 2) ? 2'b11 : ((w == 2) ? 2'b10 : 2'b01);
                if (w < 2) begin
                    e_bhrv = 1'b1;
                    e_bhr  = (w == 0) ? bhr_update_ROB : bhr_update_BR;
                end
                if (m_stat[w] != 16'hFFFF) m_stat[w] = m_stat[w] + 16'd1;
            end else if (m_bubbles > 0) begin
                m_bubbles--;
            end else if (!stall_in && !ic_stall) begin
                m_pc = line_of(m_pc) + 32'd16;
            end
        end
    endtask

    task automatic compare_model();
        logic exp_valid;
        exp_valid = !m_booting && (m_bubbles == 0);
        check("rnd.valid", 32'(fetch_valid), 32'(exp_valid));
        check("rnd.pc", fetch_pc, m_pc);
        check("rnd.even", cache_addr_even, exp_even(m_pc));
        check("rnd.odd", cache_addr_odd, exp_odd(m_pc));
        check("rnd.flush_f1", 32'(flush_f1), 32'(e_flush));
        check("rnd.flush_f2", 32'(flush_f2), 32'(e_flush));
        check("rnd.src", 32'(redirect_src), 32'(e_src));
        check("rnd.bhrv", 32'(bhr_restore_valid), 32'(e_bhrv));
        if (e_bhrv) check("rnd.bhr", 32'(bhr_restore), 32'(e_bhr));
`ifdef REDIRECT_STATS_EN
        check("rnd.stat_rob", 32'(stat_rob), 32'(m_stat[0]));
        check("rnd.stat_br",  32'(stat_br),  32'(m_stat[1]));
        check("rnd.stat_d1",  32'(stat_d1),  32'(m_stat[2]));
        check("rnd.stat_ras", 32'(stat_ras), 32'(m_stat[3]));
`endif
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic        stall;
        logic        icst;
        logic [3:0]  req;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] even;
        logic [31:0] odd;
        logic [1:0]  src;
        logic        flush;
        logic        bhrv;
        logic [9:0]  bhr;
    } vec_t;

    localparam int c_nvec = 25;
    vec_t vecs[c_nvec];

    initial begin
        //          stall icst req      vld pc            even          odd           src    fl   bv   bhr
        vecs[0]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 32'h100,  32'h100,  32'h110,  2'b00, 1'b0, 1'b0, 10'h0};
        vecs[1]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 32'h110,  32'h120,  32'h110,  2'b00, 1'b0, 1'b0, 10'h0};
        vecs[2]  = '{1'b0, 1'b0, 4'b0001, 1'b0, 32'h200,  32'h200,  32'h210,  2'b01, 1'b1, 1'b0, 10'h0};
        vecs[3]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 32'h200,  32'h200,  32'h210,  2'b00, 1'b0, 1'b0, 10'h0};
        vecs[4]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 32'h200,  32'h200,  32'h210,  2'b00, 1'b0, 1'b0, 10'h0};
        vecs[5]  = '{1'b0, 1'b0, 4'b1101, 1'b0, 32'h8000, 32'h8000, 32'h8010, 2'b11, 1'b1, 1'b1, 10'h2AA};
        vecs[6]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 32'h8000, 32'h8000, 32'h8010, 2'b00, 1'b0, 1'b0, 10'h0};
        vecs[7]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 32'h8000, 32'h8000, 32'h8010, 2'b00, 1'b0, 1'b0, 10'h0};
        vecs[8]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 32'h8010, 32'h8020, 32'h8010, 2'b00, 1'b0, 1'b0, 10'h0};
        vecs[9]  = '{1'b1, 1'b0, 4'b0100, 1'b0, 32'h404,  32'h400,  32'h410,  2'b11, 1'b1, 1'b1, 10'h155};
        vecs[10] = '{1'b1, 1'b0, 4'b0000, 1'b0, 32'h404,  32'h400,  32'h410,  2'b00, 1'b0, 1'b0, 10'h0};
        vecs[11] = '{1'b1, 1'b0, 4'b0000, 1'b1, 32'h404,  32'h400,  32'h410,  2'b00, 1'b0, 1'b0, 10'h0};
        vecs[12] = '{1'b1, 1'b0, 4'b0000, 1'b1, 32'h404,  32'h400,  32'h410,  2'b00, 1'b0, 1'b0, 10'h0};
        vecs[13] = '{1'b0, 1'b1, 4'b0000, 1'b1, 32'h404,  32'h400,  32'h410,  2'b00, 1'b0, 1'b0, 10'h0};
        vecs[14] = '{1'b0, 1'b0, 4'b0000, 1'b1, 32'h410,  32'h420,  32'h410,  2'b00, 1'b0, 1'b0, 10'h0};
        vecs[15] = '{1'b0, 1'b0, 4'b0001, 1'b0, 32'h200,  32'h200,  32'h210,  2'b01, 1'b1, 1'b0, 10'h0};
        vecs[16] = '{1'b0, 1'b0, 4'b0010, 1'b0, 32'h300,  32'h300,  32'h310,  2'b10, 1'b1, 1'b0, 10'h0};
        vecs[17] = '{1'b0, 1'b0, 4'b0000, 1'b0, 32'h300,  32'h300,  32'h310,  2'b00, 1'b0, 1'b0, 10'h0};
        vecs[18] = '{1'b0, 1'b0, 4'b0000, 1'b1, 32'h300,  32'h300,  32'h310,  2'b00, 1'b0, 1'b0, 10'h0};
        vecs[19] = '{1'b0, 1'b0, 4'b0111, 1'b0, 32'h404,  32'h400,  32'h410,  2'b11, 1'b1, 1'b1, 10'h155};
        vecs[20] = '{1'b0, 1'b0, 4'b0000, 1'b0, 32'h404,  32'h400,  32'h410,  2'b00, 1'b0, 1'b0, 10'h0};
        vecs[21] = '{1'b0, 1'b0, 4'b0000, 1'b1, 32'h404,  32'h400,  32'h410,  2'b00, 1'b0, 1'b0, 10'h0};
        vecs[22] = '{1'b0, 1'b0, 4'b0011, 1'b0, 32'h300,  32'h300,  32'h310,  2'b10, 1'b1, 1'b0, 10'h0};
        vecs[23] = '{1'b0, 1'b0, 4'b0000, 1'b0, 32'h300,  32'h300,  32'h310,  2'b00, 1'b0, 1'b0, 10'h0};
        vecs[24] = '{1'b0, 1'b0, 4'b0000, 1'b1, 32'h300,  32'h300,  32'h310,  2'b00, 1'b0, 1'b0, 10'h0};

        resteer_target_ROB = 32'h8000;
        bhr_update_ROB     = 10'h2AA;
        resteer_target_BR  = 32'h404;
        bhr_update_BR      = 10'h155;
        resteer_target_D1  = 32'h300;
        ras_target         = 32'h200;

        // ---- reset, then the BOOT cycle ----
        step();
        step();
        check("rst.valid", 32'(fetch_valid), 32'd0);
        check("rst.pc", fetch_pc, c_reset_pc);
        rst = 1'b1;
        check("boot.valid", 32'(fetch_valid), 32'd0);
        check("boot.flush", 32'(flush_f1), 32'd0);
        check("boot.src", 32'(redirect_src), 32'd0);
        check("boot.bhrv", 32'(bhr_restore_valid), 32'd0);

        for (int i = 0; i < c_nvec; i++) begin
            stall_in = vecs[i].stall;
            ic_stall = vecs[i].icst;
            drive_req(vecs[i].req);
            step();
            check($sformatf("v%0d.valid", i), 32'(fetch_valid), 32'(vecs[i].valid));
            check($sformatf("v%0d.pc", i), fetch_pc, vecs[i].pc);
            check($sformatf("v%0d.even", i), cache_addr_even, vecs[i].even);
            check($sformatf("v%0d.odd", i), cache_addr_odd, vecs[i].odd);
            check($sformatf("v%0d.f1", i), 32'(flush_f1), 32'(vecs[i].flush));
            check($sformatf("v%0d.f2", i), 32'(flush_f2), 32'(vecs[i].flush));
            check($sformatf("v%0d.src", i), 32'(redirect_src), 32'(vecs[i].src));
            check($sformatf("v%0d.bhrv", i), 32'(bhr_restore_valid), 32'(vecs[i].bhrv));
            if (vecs[i].bhrv) check($sformatf("v%0d.bhr", i), 32'(bhr_restore), 32'(vecs[i].bhr));
        end

        // ---- wrap-around at the top of the address space ----
        stall_in   = 1'b0;
        ic_stall   = 1'b0;
        ras_target = 32'hFFFF_FFF4;
        drive_req(4'b0001);
        step();
        drive_req(4'b0000);
        check("wrap.pc", fetch_pc, 32'hFFFF_FFF4);
        check("wrap.odd", cache_addr_odd, 32'hFFFF_FFF0);
        check("wrap.even", cache_addr_even, 32'h0000_0000);
        step();
        step();
        check("wrap.valid", 32'(fetch_valid), 32'd1);
        step();
        check("wrap.next_pc", fetch_pc, 32'h0000_0000);
        check("wrap.next_odd", cache_addr_odd, 32'h0000_0010);

        // ---- fresh reset, counted redirects, async reset mid-FLUSH ----
        rst = 1'b0;
        #1;
        check("arst1.valid", 32'(fetch_valid), 32'd0);
        check("arst1.pc", fetch_pc, c_reset_pc);
        step();
        rst        = 1'b1;
        ras_target = 32'h200;
        step();
        drive_req(4'b0001);
        step();
        step();
        step();
        drive_req(4'b1000);
        step();
        drive_req(4'b0000);
        check("seq.pc", fetch_pc, 32'h8000);
        check("seq.src", 32'(redirect_src), 32'd3);
        check("seq.bhr", 32'(bhr_restore), 32'h2AA);
`ifdef REDIRECT_STATS_EN
        check("seq.stat_ras", 32'(stat_ras), 32'd3);
        check("seq.stat_rob", 32'(stat_rob), 32'd1);
        check("seq.stat_br", 32'(stat_br), 32'd0);
        check("seq.stat_d1", 32'(stat_d1), 32'd0);
`endif
        #2 rst = 1'b0;
        #1;
        check("arst2.valid", 32'(fetch_valid), 32'd0);
        check("arst2.pc", fetch_pc, c_reset_pc);
        check("arst2.flush", 32'(flush_f1), 32'd0);
        check("arst2.src", 32'(redirect_src), 32'd0);
        check("arst2.bhrv", 32'(bhr_restore_valid), 32'd0);
`ifdef REDIRECT_STATS_EN
        check("arst2.stat_ras", 32'(stat_ras), 32'd0);
        check("arst2.stat_rob", 32'(stat_rob), 32'd0);
`endif
        #2 rst = 1'b1;
        model_reset();

        // ---- randomized run against the reference model ----
        for (int c = 0; c < 3000; c++) begin
            stall_in           = ($urandom_range(0, 3) == 0);
            ic_stall           = ($urandom_range(0, 4) == 0);
            exception_ROB      = ($urandom_range(0, 15) == 0);
            mispredict_BR      = ($urandom_range(0, 11) == 0);
            resteer_taken_D1   = ($urandom_range(0, 9) == 0);
            ras_valid          = ($urandom_range(0, 9) == 0);
            resteer_target_ROB = $urandom;
            resteer_target_BR  = $urandom;
            resteer_target_D1  = $urandom;
            ras_target         = ($urandom_range(0, 3) == 0)
                                 ? (32'hFFFF_FFC0 | ($urandom & 32'h3F)) : $urandom;
            bhr_update_ROB     = 10'($urandom);
            bhr_update_BR      = 10'($urandom);
            model_cycle();
            step();
            compare_model();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
Front-end fetch sequencer that owns the fetch PC. It arbitrates the redirect sources (ROB exception, BR mispredict, D1 predecode, RAS) by fixed priority, and generates the even/odd I$ line addresses. It sequences the flush/refill of the F1/F2 stages and restores the BHR on a redirect. It sits ahead of the fetch-1 stage and replaces the PC-generation and resteer-muxing logic in the control stage.

Parameters:
XLEN, 32, address width
CL_SIZE, 128, cache line size in bits; LINE_BYTES = CL_SIZE/8
RESET_PC, 32'h0000_0000, first fetch address after reset
FLUSH_CYCLES, 2, bubble cycles after a redirect (1..7)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
stall_in  in  1  back-end stall
ic_stall  in  1  I$ not ready
exception_ROB  in  1  ROB redirect request
resteer_target_ROB  in  XLEN  ROB target
bhr_update_ROB  in  10  BHR to restore on ROB redirect
mispredict_BR  in  1  branch-unit redirect request
resteer_target_BR  in  XLEN  BR target
bhr_update_BR  in  10  BHR to restore on BR redirect
resteer_taken_D1  in  1  D1 predecode redirect request
resteer_target_D1  in  XLEN  D1 target
ras_valid  in  1  RAS return redirect request
ras_target  in  XLEN  RAS target
fetch_valid  out  1  addresses below are valid this cycle
fetch_pc  out  XLEN  current fetch PC
cache_addr_even  out  XLEN  even-indexed line address
cache_addr_odd  out  XLEN  odd-indexed line address
flush_f1  out  1  kill F1 contents
flush_f2  out  1  kill F2 contents / IBuff
redirect_src  out  2  00 none, 01 RAS, 10 D1, 11 BR/ROB (see bhr_src)
bhr_restore_valid  out  1  BHR restore strobe
bhr_restore  out  10  restored BHR value

Behaviour:
- Reset (rst low, asynchronous): state = BOOT, fetch_pc = RESET_PC, fetch_valid = 0, all flushes and strobes = 0, flush counter = 0.
- States:
  - BOOT: lasts 1 cycle with fetch_valid = 0, then goes to RUN.
  - RUN: fetch_valid = 1.
  - FLUSH: fetch_valid = 0 and the counter counts FLUSH_CYCLES down to 0, then the state goes to RUN.
- Advance: fetch_pc advances when the state is RUN, stall_in = 0, ic_stall = 0 and there is no redirect. The update is fetch_pc <= (fetch_pc & ~(LINE_BYTES-1)) + LINE_BYTES, with XLEN wrap-around (0xFFFF_FFF0 + 16 becomes 0).
- Line addresses (combinational from fetch_pc):
  - L = fetch_pc aligned down to the line; idx = L[log2(LINE_BYTES)].
  - If idx = 0: even = L, odd = L + LINE_BYTES.
  - If idx = 1: odd = L, even = L + LINE_BYTES.
  - Both addresses wrap modulo 2^XLEN.
- Redirect priority: ROB > BR > D1 > RAS. Only the winning request is used; all lower-priority requests in the same cycle are dropped.
- Redirects are accepted in any state other than BOOT, regardless of stall_in or ic_stall.
  - A request during BOOT is ignored.
- Next cycle after a winning request:
  - fetch_pc = the winner's target, with no alignment applied.
  - State = FLUSH and the counter is loaded with FLUSH_CYCLES.
  - flush_f1 and flush_f2 pulse high for exactly 1 cycle.
  - redirect_src is set for that same 1 cycle; ROB and BR both encode as 11.
- BHR restore:
  - For a ROB or BR winner, bhr_restore_valid pulses for 1 cycle together with the flush pulse.
  - bhr_restore = bhr_update_ROB or bhr_update_BR respectively.
  - D1 and RAS winners produce no BHR restore.
- Redirect during FLUSH: the new winner replaces fetch_pc, the counter reloads to FLUSH_CYCLES, and the flush pulse is repeated.
- Stall during FLUSH: the counter still decrements, and fetch_valid rises in RUN even while stalled. While stalled, fetch_pc holds.
- All outputs are registered except cache_addr_even and cache_addr_odd.

Optional Feature:
REDIRECT_STATS_EN:
- When defined, the block adds outputs stat_rob, stat_br, stat_d1 and stat_ras, each 16 bits.
- Each is a saturating count (stops at 0xFFFF) of accepted winning redirects per source, cleared on reset.
- When not defined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Release reset with RESET_PC = 0x100, no stalls:
  - Cycle 1: fetch_valid = 0.
  - Next: fetch_pc = 0x100, even = 0x100, odd = 0x110.
  - Next: fetch_pc = 0x110, even = 0x120, odd = 0x110.
- In RUN at pc 0x200, raise exception_ROB (target 0x8000, bhr 0x2AA), mispredict_BR and ras_valid in the same cycle:
  - Next cycle: fetch_pc = 0x8000, redirect_src = 11, bhr_restore = 0x2AA with valid, both flush pulses high.
  - fetch_valid low for 2 cycles, then high with pc 0x8000.
- mispredict_BR (target 0x404) while stall_in = 1:
  - Redirect is accepted; fetch_pc = 0x404, even = 0x400, odd = 0x410.
  - fetch_pc holds 0x404 while the stall persists after FLUSH.
- resteer_taken_D1 (target 0x300) during FLUSH cycle 1:
  - Counter reloads; fetch_valid stays low 2 more cycles; second flush pulse; redirect_src = 10; no bhr_restore_valid.
- fetch_pc = 0xFFFF_FFF4, no stall:
  - Next fetch_pc = 0x0000_0000; at 0xFFFF_FFF4, odd = 0xFFFF_FFF0 and even = 0x0000_0000.
- With REDIRECT_STATS_EN defined:
  - 3 RAS redirects and 1 ROB redirect give stat_ras = 3, stat_rob = 1.
  - An asynchronous rst pulse mid-FLUSH clears the counters, fetch_valid and the state immediately.
